// File: rtl/uib_pkg.sv
// uib_pkg: shared defaults, FSM state encoding and constants for the uib arbiter.
package uib_pkg;

   localparam int DEF_MST_W   = 1;
   localparam int DEF_SLV_W   = 3;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MODE_W  = 3;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   localparam logic [DEF_DATA_W-1:0] ERR_RDATA = '0;

   // Wait counter must hold TIMEOUT-1 and is never narrower than 8 bits.
   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/uib_rr_pick.sv
// uib_rr_pick: combinational round-robin selector; the first requester after i_last wins,
// with i_last itself having the lowest priority.
module uib_rr_pick #(
   parameter int W = 1
)(
   input  logic [2**W-1:0] i_req,
   input  logic [W-1:0]    i_last,
   output logic            o_valid,
   output logic [W-1:0]    o_idx
);

   localparam int N = 2**W;

   logic [W-1:0] w_cand;

   // Scan from farthest to nearest so the closest requester after i_last is written last and wins.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int i = N; i >= 1; i--) begin
         w_cand  = i_last + W'(i);
         o_idx   = i_req[w_cand] ? w_cand : o_idx;
         o_valid = o_valid | i_req[w_cand];
      end
   end

endmodule

// File: rtl/uib_arbiter.sv
// uib_arbiter: round-robin arbiter connecting NM masters to NS slaves one transfer at a time,
// completing a transfer with an error strobe when the slave does not answer within TIMEOUT cycles.
module uib_arbiter
   import uib_pkg::*;
#(
   parameter  int MST_W   = DEF_MST_W,
   parameter  int SLV_W   = DEF_SLV_W,
   parameter  int DATA_W  = DEF_DATA_W,
   parameter  int MODE_W  = DEF_MODE_W,
   parameter  int TIMEOUT = DEF_TIMEOUT,
   localparam int NM      = 2**MST_W,
   localparam int NS      = 2**SLV_W,
   localparam int AW      = DATA_W - SLV_W
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NM-1:0][DATA_W-1:0]     master_dat_i,
   output logic [NM-1:0][DATA_W-1:0]     master_dat_o,
   input  logic [NM-1:0][AW-1:0]         master_addr,
   input  logic [NM-1:0][SLV_W-1:0]      master_num,
   input  logic [NM-1:0]                 master_req,
   input  logic [NM-1:0]                 master_wen,
   input  logic [NM-1:0][MODE_W-1:0]     master_mode,
   output logic [NM-1:0]                 master_ready,
   output logic [NM-1:0]                 master_err,
   input  logic [NS-1:0][DATA_W-1:0]     slave_dat_i,
   output logic [NS-1:0][DATA_W-1:0]     slave_dat_o,
   output logic [NS-1:0][AW-1:0]         slave_addr,
   output logic [NS-1:0]                 slave_req,
   output logic [NS-1:0]                 slave_wen,
   output logic [NS-1:0][MODE_W-1:0]     slave_mode,
   input  logic [NS-1:0]                 slave_ready
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   state_t             r_state;
   logic [MST_W-1:0]   r_gnt;
   logic [SLV_W-1:0]   r_sel;
   logic [MST_W-1:0]   r_last;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_pick_valid;
   logic [MST_W-1:0]   w_pick_idx;
   logic               w_done;

   uib_rr_pick #(.W(MST_W)) u_pick (
      .i_req   (master_req),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   // Arbitration state: grant, latched slave, round-robin pointer and timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_sel   <= '0;
         r_last  <= '1;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_gnt   <= w_pick_idx;
                  r_sel   <= master_num[w_pick_idx];
                  r_cnt   <= '0;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Ready is tested before the timeout so a last-cycle answer completes normally.
               if (!master_req[r_gnt]) begin
                  r_state <= ST_IDLE;
               end else if (slave_ready[r_sel]) begin
                  r_state <= ST_IDLE;
                  r_last  <= r_gnt;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_state <= ST_ERR;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_ERR: begin
               r_state <= ST_IDLE;
               r_last  <= r_gnt;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_done = master_req[r_gnt] & slave_ready[r_sel];

   // Crossbar routing: only the granted master and the latched slave see non-zero values.
   always_comb begin
      master_dat_o = '0;
      master_ready = '0;
      master_err   = '0;
      slave_dat_o  = '0;
      slave_addr   = '0;
      slave_req    = '0;
      slave_wen    = '0;
      slave_mode   = '0;
      case (r_state)
         ST_BUSY: begin
            slave_req[r_sel]    = master_req[r_gnt];
            slave_dat_o[r_sel]  = master_dat_i[r_gnt];
            slave_addr[r_sel]   = master_addr[r_gnt];
            slave_wen[r_sel]    = master_wen[r_gnt];
            slave_mode[r_sel]   = master_mode[r_gnt];
            master_ready[r_gnt] = w_done;
            master_dat_o[r_gnt] = w_done ? slave_dat_i[r_sel] : '0;
         end
         ST_ERR: begin
            master_ready[r_gnt] = 1'b1;
            master_err[r_gnt]   = 1'b1;
            master_dat_o[r_gnt] = DATA_W'(ERR_RDATA);
         end
         default: begin
            master_ready = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uib_arbiter.sv
// tb_uib_arbiter: randomized self-checking bench; a transaction-level round-robin model
// predicts which master each transfer belongs to and what it returns.
module tb_uib_arbiter;

   localparam int MST_W   = 1;
   localparam int SLV_W   = 3;
   localparam int DATA_W  = 32;
   localparam int MODE_W  = 3;
   localparam int TIMEOUT = 255;
   localparam int NM      = 2**MST_W;
   localparam int NS      = 2**SLV_W;
   localparam int AW      = DATA_W - SLV_W;
   localparam int W_ALL   = NM*DATA_W + 2*NM + NS*(DATA_W + AW + 2 + MODE_W);

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NM-1:0][DATA_W-1:0] master_dat_i;
   logic [NM-1:0][DATA_W-1:0] master_dat_o;
   logic [NM-1:0][AW-1:0]     master_addr;
   logic [NM-1:0][SLV_W-1:0]  master_num;
   logic [NM-1:0]             master_req;
   logic [NM-1:0]             master_wen;
   logic [NM-1:0][MODE_W-1:0] master_mode;
   logic [NM-1:0]             master_ready;
   logic [NM-1:0]             master_err;
   logic [NS-1:0][DATA_W-1:0] slave_dat_i;
   logic [NS-1:0][DATA_W-1:0] slave_dat_o;
   logic [NS-1:0][AW-1:0]     slave_addr;
   logic [NS-1:0]             slave_req;
   logic [NS-1:0]             slave_wen;
   logic [NS-1:0][MODE_W-1:0] slave_mode;
   logic [NS-1:0]             slave_ready;
   logic [W_ALL-1:0]          all_out;

   int checks = 0;
   int errors = 0;
   int rdy_cnt [NM];
   int err_cnt = 0;

   uib_arbiter #(
      .MST_W(MST_W), .SLV_W(SLV_W), .DATA_W(DATA_W), .MODE_W(MODE_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .master_dat_i(master_dat_i), .master_dat_o(master_dat_o), .master_addr(master_addr),
      .master_num(master_num), .master_req(master_req), .master_wen(master_wen),
      .master_mode(master_mode), .master_ready(master_ready), .master_err(master_err),
      .slave_dat_i(slave_dat_i), .slave_dat_o(slave_dat_o), .slave_addr(slave_addr),
      .slave_req(slave_req), .slave_wen(slave_wen), .slave_mode(slave_mode),
      .slave_ready(slave_ready)
   );

   assign all_out = {master_dat_o, master_ready, master_err, slave_dat_o, slave_addr,
                     slave_req, slave_wen, slave_mode};

   always #5 clk = ~clk;

   // Count completion and error strobes per master.
   always @(negedge clk) begin
      if (!rst) begin
         for (int m = 0; m < NM; m++) begin
            if (master_ready[m]) rdy_cnt[m]++;
         end
         if (|master_err) err_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      master_req  = '0;
      slave_ready = '0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic new_request(input int m);
      master_num[m]   = SLV_W'($urandom_range(0, NS-1));
      master_addr[m]  = AW'($urandom);
      master_dat_i[m] = $urandom;
      master_mode[m]  = MODE_W'($urandom);
      master_wen[m]   = 1'($urandom);
      master_req[m]   = 1'b1;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      master_dat_i = '0; master_addr = '0; master_num = '0; master_req = '0;
      master_wen   = '0; master_mode = '0; slave_dat_i = '0; slave_ready = '0;
      #3;
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      tick();
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL post_reset_outputs: got %h expected 0", all_out);
      end
   endtask

   task automatic test_single_read();
      logic [NS-1:0][AW-1:0]     e_addr;
      logic [NS-1:0][DATA_W-1:0] e_dat;
      logic [NS-1:0][MODE_W-1:0] e_mode;
      int r0;
      do_reset();
      new_request(0);
      master_num[0] = 3'd3;
      master_wen[0] = 1'b0;
      new_request(1);
      master_req[1] = 1'b0;
      r0 = rdy_cnt[0];
      e_addr = '0; e_addr[3] = master_addr[0];
      e_dat  = '0; e_dat[3]  = master_dat_i[0];
      e_mode = '0; e_mode[3] = master_mode[0];
      tick();
      checks++;
      if (slave_req !== 8'b0000_1000 || slave_wen !== 8'b0 || master_ready !== 2'b00) begin
         errors++; $display("FAIL single_route_ctrl: got req %b wen %b rdy %b expected req 00001000 wen 0 rdy 00",
                            slave_req, slave_wen, master_ready);
      end
      checks++;
      if (slave_addr !== e_addr || slave_dat_o !== e_dat || slave_mode !== e_mode) begin
         errors++; $display("FAIL single_route_data: got addr %h dat %h mode %h expected addr %h dat %h mode %h",
                            slave_addr, slave_dat_o, slave_mode, e_addr, e_dat, e_mode);
      end
      tick();
      slave_dat_i[3] = 32'h1234_5678;
      slave_ready[3] = 1'b1;
      #1;
      checks++;
      if (master_ready !== 2'b01 || master_err !== 2'b00 || master_dat_o[0] !== 32'h1234_5678 ||
          master_dat_o[1] !== 32'h0) begin
         errors++; $display("FAIL single_complete: got rdy %b err %b dat %h expected rdy 01 err 00 dat 0000000012345678",
                            master_ready, master_err, master_dat_o);
      end
      tick();
      slave_ready    = '0;
      master_req     = '0;
      tick();
      checks++;
      if (rdy_cnt[0] - r0 != 1 || all_out !== '0) begin
         errors++; $display("FAIL single_once: got %0d strobes expected 1 (outputs %h)", rdy_cnt[0] - r0, all_out);
      end
   endtask

   // fixed > 0 gives every master that many transfers; 0 picks random counts.
   task automatic test_rr(input int fixed);
      int rem [NM];
      int total, exp_last, exp_m, lat, wait_c, s, c;
      logic [DATA_W-1:0] rd;
      do_reset();
      exp_last = NM - 1;
      total    = 0;
      for (int m = 0; m < NM; m++) begin
         rem[m] = (fixed > 0) ? fixed : $urandom_range(0, 6);
         total += rem[m];
         if (rem[m] > 0) new_request(m);
      end
      while (total > 0) begin
         exp_m = -1;
         for (int k = 1; k <= NM; k++) begin
            c = (exp_last + k) % NM;
            if (exp_m < 0 && rem[c] > 0) exp_m = c;
         end
         s = int'(master_num[exp_m]);
         wait_c = 0;
         do begin
            tick();
            wait_c++;
         end while (slave_req === '0 && wait_c < 4);
         checks++;
         if (wait_c != 1) begin
            errors++; $display("FAIL rr_latency: got %0d cycles expected 1", wait_c);
         end
         checks++;
         if (slave_req !== (NS'(1) << s) || slave_dat_o[s] !== master_dat_i[exp_m]) begin
            errors++; $display("FAIL rr_grant: got slave_req %b expected %b for master %0d",
                               slave_req, NS'(1) << s, exp_m);
         end
         lat = $urandom_range(0, 3);
         repeat (lat) tick();
         rd = $urandom;
         slave_dat_i[s] = rd;
         slave_ready[s] = 1'b1;
         #1;
         checks++;
         if (master_ready !== (NM'(1) << exp_m) || master_err !== '0 || master_dat_o[exp_m] !== rd) begin
            errors++; $display("FAIL rr_complete: got rdy %b err %b dat %h expected rdy %b err 0 dat %h",
                               master_ready, master_err, master_dat_o[exp_m], NM'(1) << exp_m, rd);
         end
         tick();
         slave_ready = '0;
         rem[exp_m]--;
         total--;
         exp_last = exp_m;
         if (rem[exp_m] == 0) master_req[exp_m] = 1'b0;
         else new_request(exp_m);
      end
      tick();
   endtask

   task automatic test_timeout();
      int n, e0;
      master_req = '0;
      slave_ready = '0;
      new_request(1);
      master_num[1]  = 3'd5;
      master_wen[1]  = 1'b1;
      slave_dat_i[5] = 32'hDEAD_BEEF;
      e0 = err_cnt;
      tick();
      checks++;
      if (slave_req !== 8'b0010_0000 || slave_wen !== 8'b0010_0000) begin
         errors++; $display("FAIL timeout_write_route: got req %b wen %b expected 00100000", slave_req, slave_wen);
      end
      n = 0;
      while (master_ready === '0 && n < TIMEOUT + 10) begin
         tick();
         n++;
      end
      checks++;
      if (n != TIMEOUT) begin
         errors++; $display("FAIL timeout_latency: got %0d busy cycles expected %0d", n, TIMEOUT);
      end
      checks++;
      if (master_ready !== 2'b10 || master_err !== 2'b10 || master_dat_o !== '0 || slave_req !== '0) begin
         errors++; $display("FAIL timeout_err: got rdy %b err %b dat %h sreq %b expected rdy 10 err 10 dat 0 sreq 0",
                            master_ready, master_err, master_dat_o, slave_req);
      end
      master_req[1] = 1'b0;
      tick();
      checks++;
      if (all_out !== '0 || err_cnt - e0 != 1) begin
         errors++; $display("FAIL timeout_single_err: got %0d err strobes expected 1 (outputs %h)", err_cnt - e0, all_out);
      end
   endtask

   task automatic test_ready_at_limit();
      int e0;
      logic [DATA_W-1:0] rd;
      new_request(0);
      master_num[0] = 3'd2;
      e0 = err_cnt;
      tick();
      repeat (TIMEOUT - 1) tick();
      checks++;
      if (master_ready !== 2'b00 || slave_req !== 8'b0000_0100) begin
         errors++; $display("FAIL limit_still_busy: got rdy %b sreq %b expected rdy 00 sreq 00000100",
                            master_ready, slave_req);
      end
      rd = $urandom;
      slave_dat_i[2] = rd;
      slave_ready[2] = 1'b1;
      #1;
      checks++;
      if (master_ready !== 2'b01 || master_err !== 2'b00 || master_dat_o[0] !== rd) begin
         errors++; $display("FAIL limit_ready_wins: got rdy %b err %b dat %h expected rdy 01 err 00 dat %h",
                            master_ready, master_err, master_dat_o[0], rd);
      end
      tick();
      slave_ready = '0;
      master_req  = '0;
      tick();
      checks++;
      if (err_cnt != e0 || all_out !== '0) begin
         errors++; $display("FAIL limit_no_err: got %0d err strobes expected 0 (outputs %h)", err_cnt - e0, all_out);
      end
   endtask

   task automatic test_reset_mid();
      int r1;
      master_req = '0;
      new_request(1);
      master_num[1] = 3'd4;
      r1 = rdy_cnt[1];
      tick();
      checks++;
      if (slave_req !== 8'b0001_0000) begin
         errors++; $display("FAIL midrst_busy: got sreq %b expected 00010000", slave_req);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL midrst_async: got %h expected 0", all_out);
      end
      @(posedge clk);
      #1;
      new_request(0);
      master_num[0] = 3'd6;
      master_req    = 2'b11;
      #5 rst = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL midrst_after: got %h expected 0", all_out);
      end
      tick();
      checks++;
      if (slave_req !== 8'b0100_0000) begin
         errors++; $display("FAIL midrst_first_grant: got sreq %b expected 01000000 (master 0)", slave_req);
      end
      slave_ready[6] = 1'b1;
      #1;
      tick();
      slave_ready = '0;
      master_req  = '0;
      tick();
      checks++;
      if (rdy_cnt[1] != r1) begin
         errors++; $display("FAIL midrst_dropped: got %0d master 1 strobes expected 0", rdy_cnt[1] - r1);
      end
   endtask

   task automatic test_abort();
      int r0;
      logic [DATA_W-1:0] rd;
      do_reset();
      new_request(0);
      new_request(1);
      master_num[0] = 3'd1;
      master_num[1] = 3'd7;
      r0 = rdy_cnt[0];
      tick();
      checks++;
      if (slave_req !== 8'b0000_0010) begin
         errors++; $display("FAIL abort_grant0: got sreq %b expected 00000010", slave_req);
      end
      master_req[0] = 1'b0;
      #1;
      checks++;
      if (slave_req !== '0 || master_ready !== '0) begin
         errors++; $display("FAIL abort_drop: got sreq %b rdy %b expected 0", slave_req, master_ready);
      end
      tick();
      checks++;
      if (slave_req !== '0 || master_ready !== '0) begin
         errors++; $display("FAIL abort_idle: got sreq %b rdy %b expected 0", slave_req, master_ready);
      end
      tick();
      checks++;
      if (slave_req !== 8'b1000_0000) begin
         errors++; $display("FAIL abort_grant1: got sreq %b expected 10000000", slave_req);
      end
      rd = $urandom;
      slave_dat_i[7] = rd;
      slave_ready[7] = 1'b1;
      #1;
      checks++;
      if (master_ready !== 2'b10 || master_dat_o[1] !== rd || rdy_cnt[0] != r0) begin
         errors++; $display("FAIL abort_complete1: got rdy %b dat %h m0 strobes %0d expected rdy 10 dat %h m0 strobes 0",
                            master_ready, master_dat_o[1], rdy_cnt[0] - r0, rd);
      end
      tick();
      slave_ready = '0;
      master_req  = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_rr(4);
      test_rr(0);
      test_rr(0);
      test_timeout();
      test_ready_at_limit();
      test_reset_mid();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
